// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-bus controller: FSM state encoding,
// command write-bit position and the default status byte.
package spi_reg_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_CMD      = 3'd1;
  localparam state_t ST_WR_DATA  = 3'd2;
  localparam state_t ST_RD_FETCH = 3'd3;
  localparam state_t ST_RD_LOAD  = 3'd4;
  localparam state_t ST_RD_WAIT  = 3'd5;

  localparam int CMD_WR_BIT = 7;

  localparam logic [7:0] STATUS_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/spi_reg_ctrl.sv
// SPI-frame to register-bus bridge: command byte selects read/write and start address.
// Define SPI_REG_CTRL_AUTOINC_EN to advance the address per access; otherwise it stays fixed.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | no frame; waiting for registered cs 1->0
// ST_CMD      | status byte offered; waiting for the command byte
// ST_WR_DATA  | each received byte becomes a register write
// ST_RD_FETCH | reg_re is high this cycle
// ST_RD_LOAD  | reg_rdata valid; loaded into tx_byte
// ST_RD_WAIT  | waiting for the master to clock out the byte
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata
);

`ifdef SPI_REG_CTRL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  state_t            state;
  logic              cs_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] addr_nxt;

  // Natural ADDR_W-bit overflow gives the max->0 wrap.
  always_comb begin
    addr_nxt = cur_addr;
    if (AUTOINC) addr_nxt = cur_addr + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cs_q      <= 1'b1;
      cur_addr  <= '0;
      tx_byte   <= 8'h00;
      tx_valid  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
    end else begin
      cs_q     <= cs;
      tx_valid <= 1'b0;
      reg_we   <= 1'b0;
      reg_re   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cs_q && !cs) begin
            state    <= ST_CMD;
            tx_byte  <= STATUS_BYTE;
            tx_valid <= 1'b1;
          end
        end

        ST_CMD: begin
          if (cs) begin
            state <= ST_IDLE;
          end else if (rx_valid) begin
            cur_addr <= rx_byte[ADDR_W-1:0];
            if (rx_byte[CMD_WR_BIT]) begin
              state <= ST_WR_DATA;
            end else begin
              // Strobe is registered so it is high for exactly the RD_FETCH cycle.
              state    <= ST_RD_FETCH;
              reg_re   <= 1'b1;
              reg_addr <= rx_byte[ADDR_W-1:0];
            end
          end
        end

        ST_WR_DATA: begin
          if (cs) begin
            state <= ST_IDLE;
          end else if (rx_valid) begin
            reg_we    <= 1'b1;
            reg_wdata <= rx_byte;
            reg_addr  <= cur_addr;
            cur_addr  <= addr_nxt;
          end
        end

        ST_RD_FETCH: begin
          if (cs) state <= ST_IDLE;
          else    state <= ST_RD_LOAD;
        end

        ST_RD_LOAD: begin
          if (cs) begin
            state <= ST_IDLE;
          end else begin
            tx_byte  <= reg_rdata;
            tx_valid <= 1'b1;
            cur_addr <= addr_nxt;
            state    <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (cs) begin
            state <= ST_IDLE;
          end else if (rx_valid) begin
            state    <= ST_RD_FETCH;
            reg_re   <= 1'b1;
            reg_addr <= cur_addr;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomized self-checking bench for spi_reg_ctrl against a frame-level reference model.
// Honors SPI_REG_CTRL_AUTOINC_EN the same way the design does.
module tb_spi_reg_ctrl;

  localparam int         AW   = 7;
  localparam logic [7:0] STAT = 8'hA5;

`ifdef SPI_REG_CTRL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cs = 1'b1;
  logic [7:0]    rx_byte = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_byte;
  logic          tx_valid;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic [7:0]    reg_rdata = 8'h00;
  logic          init_req = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int excl_err = 0;

  always #5 clk = ~clk;

  spi_reg_ctrl #(.ADDR_W(AW), .STATUS_BYTE(STAT)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata)
  );

  function automatic logic [7:0] init_val(input int i);
    if (i == 5) return 8'h3C;
    if (i == 6) return 8'h4D;
    return 8'((i * 29 + 7) % 256);
  endfunction

  // Register file on the bus side; read data is valid the cycle after reg_re.
  logic [7:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(i);
    end else if (reg_we) begin
      mem[reg_addr] <= reg_wdata;
    end
    reg_rdata <= reg_re ? mem[reg_addr] : 8'($urandom);
  end

  logic [7:0]    ref_mem [0:(1<<AW)-1];
  logic [7:0]    data_q[$];
  logic [AW-1:0] exp_wa[$], obs_wa[$], exp_ra[$], obs_ra[$];
  logic [7:0]    exp_wd[$], obs_wd[$], exp_tx[$], obs_tx[$];
  int            obs_rc[$], obs_tc[$];

  always @(negedge clk) begin
    cyc++;
    if (reg_we) begin obs_wa.push_back(reg_addr); obs_wd.push_back(reg_wdata); end
    if (reg_re) begin obs_ra.push_back(reg_addr); obs_rc.push_back(cyc); end
    if (tx_valid) begin obs_tx.push_back(tx_byte); obs_tc.push_back(cyc); end
    if (reg_we && reg_re) excl_err++;
  end

  function automatic logic [AW-1:0] step(input logic [AW-1:0] a);
    if (!AUTOINC) return a;
    return AW'((int'(a) + 1) % (1 << AW));
  endfunction

  task automatic clear_q();
    obs_wa.delete(); obs_wd.delete(); obs_ra.delete(); obs_rc.delete();
    obs_tx.delete(); obs_tc.delete();
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete(); exp_tx.delete();
  endtask

  task automatic send_rx(input logic [7:0] b, input bit raise);
    @(posedge clk); #1;
    rx_byte = b; rx_valid = 1'b1;
    if (raise) cs = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_byte = 8'($urandom);
  endtask

  // Builds the expected frame outcome from the command rules, then drives the frame.
  task automatic run_frame(input logic [7:0] cmd, input bit abort_last);
    logic [AW-1:0] a;
    int n;
    n = data_q.size();
    a = cmd[AW-1:0];
    clear_q();
    exp_tx.push_back(STAT);
    if (cmd[7]) begin
      for (int i = 0; i < n; i++) begin
        if (!(abort_last && i == n - 1)) begin
          exp_wa.push_back(a); exp_wd.push_back(data_q[i]);
          ref_mem[a] = data_q[i];
          a = step(a);
        end
      end
    end else begin
      for (int i = 0; i <= n; i++) begin
        if (!(abort_last && i == n)) begin
          exp_ra.push_back(a); exp_tx.push_back(ref_mem[a]);
          a = step(a);
        end
      end
    end
    send_rx(8'($urandom), 1'b0);
    repeat (2) @(posedge clk);
    #1 cs = 1'b0;
    repeat (2) @(posedge clk);
    send_rx(cmd, 1'b0);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(4, 7)) @(posedge clk);
      send_rx(data_q[i], abort_last && (i == n - 1));
    end
    if (!abort_last) begin
      repeat (5) @(posedge clk);
      #1 cs = 1'b1;
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; init_req = 1'b1; cs = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (tx_byte !== 8'h00) begin bad++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    total++; if (reg_we !== 1'b0 || reg_re !== 1'b0) begin bad++; $display("FAIL reset_strobes: got we=%b re=%b want 0 0", reg_we, reg_re); end
    total++; if (reg_addr !== '0 || reg_wdata !== 8'h00) begin bad++; $display("FAIL reset_bus: got addr=%h wdata=%h want 0 0", reg_addr, reg_wdata); end
    #1 init_req = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_read_basic();
    data_q = '{8'h00};
    run_frame(8'h05, 1'b0);
    total++; if (obs_ra.size() !== exp_ra.size()) begin bad++; $display("FAIL rd_count: got %0d want %0d", obs_ra.size(), exp_ra.size()); end
    for (int i = 0; i < exp_ra.size(); i++) begin
      total++;
      if (i >= obs_ra.size() || obs_ra[i] !== exp_ra[i]) begin bad++; $display("FAIL rd_addr[%0d]: got %h want %h", i, (i < obs_ra.size()) ? obs_ra[i] : 'x, exp_ra[i]); end
      total++;
      if (i >= obs_rc.size() || i + 1 >= obs_tc.size() || obs_tc[i+1] - obs_rc[i] !== 2) begin bad++; $display("FAIL rd_latency[%0d]: got other than 2 cycles, want 2", i); end
    end
    total++; if (obs_tx.size() !== exp_tx.size()) begin bad++; $display("FAIL rd_tx_count: got %0d want %0d", obs_tx.size(), exp_tx.size()); end
    for (int i = 0; i < exp_tx.size(); i++) begin
      total++;
      if (i >= obs_tx.size() || obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL rd_tx[%0d]: got %h want %h", i, (i < obs_tx.size()) ? obs_tx[i] : 8'hxx, exp_tx[i]); end
    end
  endtask

  task automatic test_write_basic();
    data_q = '{8'h11, 8'h22};
    run_frame(8'h83, 1'b0);
    total++; if (obs_wa.size() !== exp_wa.size()) begin bad++; $display("FAIL wr_count: got %0d want %0d", obs_wa.size(), exp_wa.size()); end
    for (int i = 0; i < exp_wa.size(); i++) begin
      total++;
      if (i >= obs_wa.size() || obs_wa[i] !== exp_wa[i] || obs_wd[i] !== exp_wd[i]) begin bad++; $display("FAIL wr[%0d]: got %h/%h want %h/%h", i, (i < obs_wa.size()) ? obs_wa[i] : 'x, (i < obs_wd.size()) ? obs_wd[i] : 8'hxx, exp_wa[i], exp_wd[i]); end
    end
    total++; if (obs_tx.size() < 1 || obs_tx[0] !== STAT) begin bad++; $display("FAIL wr_status: got %h want %h", (obs_tx.size() > 0) ? obs_tx[0] : 8'hxx, STAT); end
    total++; if (obs_ra.size() !== 0) begin bad++; $display("FAIL wr_no_read: got %0d reads want 0", obs_ra.size()); end
  endtask

  task automatic test_wrap();
    data_q = '{8'hC1, 8'hC2};
    run_frame(8'hFF, 1'b0);
    total++; if (obs_wa.size() !== exp_wa.size()) begin bad++; $display("FAIL wrap_count: got %0d want %0d", obs_wa.size(), exp_wa.size()); end
    for (int i = 0; i < exp_wa.size(); i++) begin
      total++;
      if (i >= obs_wa.size() || obs_wa[i] !== exp_wa[i] || obs_wd[i] !== exp_wd[i]) begin bad++; $display("FAIL wrap[%0d]: got %h want %h", i, (i < obs_wa.size()) ? obs_wa[i] : 'x, exp_wa[i]); end
    end
  endtask

  task automatic test_cs_abort();
    data_q = '{8'hAA, 8'hBB};
    run_frame(8'h90, 1'b1);
    total++; if (obs_wa.size() !== 1) begin bad++; $display("FAIL abort_count: got %0d want 1", obs_wa.size()); end
    total++; if (obs_wa.size() < 1 || obs_wa[0] !== exp_wa[0] || obs_wd[0] !== 8'hAA) begin bad++; $display("FAIL abort_first: got %h/%h want %h/aa", (obs_wa.size() > 0) ? obs_wa[0] : 'x, (obs_wd.size() > 0) ? obs_wd[0] : 8'hxx, exp_wa[0]); end
    clear_q();
    send_rx(8'h81, 1'b0);
    send_rx(8'h42, 1'b0);
    repeat (3) @(posedge clk);
    total++; if (obs_wa.size() + obs_ra.size() + obs_tx.size() !== 0) begin bad++; $display("FAIL idle_rx: got %0d events want 0", obs_wa.size() + obs_ra.size() + obs_tx.size()); end
  endtask

  task automatic test_reset_mid();
    clear_q();
    @(posedge clk); #1 cs = 1'b0;
    repeat (2) @(posedge clk);
    send_rx(8'h81, 1'b0);
    repeat (3) @(posedge clk);
    send_rx(8'h55, 1'b0);
    ref_mem[1] = 8'h55;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rx_valid = 1'b1; rx_byte = 8'h66;
    @(posedge clk);
    @(negedge clk);
    total++; if (tx_byte !== 8'h00 || tx_valid !== 1'b0) begin bad++; $display("FAIL midrst_tx: got %h/%b want 00/0", tx_byte, tx_valid); end
    total++; if (reg_we !== 1'b0 || reg_re !== 1'b0 || reg_addr !== '0 || reg_wdata !== 8'h00) begin bad++; $display("FAIL midrst_bus: got we=%b re=%b addr=%h wd=%h want all 0", reg_we, reg_re, reg_addr, reg_wdata); end
    #1 rx_valid = 1'b0; cs = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    send_rx(8'h77, 1'b0);
    repeat (3) @(posedge clk);
    total++; if (obs_wa.size() !== 1 || obs_wd[0] !== 8'h55) begin bad++; $display("FAIL midrst_writes: got %0d writes want 1 (data 55)", obs_wa.size()); end
    data_q = '{8'h9E};
    run_frame(8'h8A, 1'b0);
    total++; if (obs_wa.size() !== 1 || obs_wa[0] !== exp_wa[0] || obs_wd[0] !== 8'h9E) begin bad++; $display("FAIL midrst_next_frame: got %0d writes want 1 to %h", obs_wa.size(), exp_wa[0]); end
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    int n;
    for (int f = 0; f < 20; f++) begin
      cmd = 8'($urandom);
      n = $urandom_range(1, 4);
      data_q.delete();
      for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
      run_frame(cmd, 1'b0);
      total++;
      if (obs_wa.size() !== exp_wa.size() || obs_ra.size() !== exp_ra.size() || obs_tx.size() !== exp_tx.size()) begin
        bad++; $display("FAIL rand_counts[%0d] cmd=%h: got w%0d r%0d t%0d want w%0d r%0d t%0d", f, cmd,
          obs_wa.size(), obs_ra.size(), obs_tx.size(), exp_wa.size(), exp_ra.size(), exp_tx.size());
      end else begin
        for (int i = 0; i < exp_wa.size(); i++) begin
          total++; if (obs_wa[i] !== exp_wa[i] || obs_wd[i] !== exp_wd[i]) begin bad++; $display("FAIL rand_wr[%0d.%0d]: got %h/%h want %h/%h", f, i, obs_wa[i], obs_wd[i], exp_wa[i], exp_wd[i]); end
        end
        for (int i = 0; i < exp_ra.size(); i++) begin
          total++; if (obs_ra[i] !== exp_ra[i]) begin bad++; $display("FAIL rand_rd[%0d.%0d]: got %h want %h", f, i, obs_ra[i], exp_ra[i]); end
        end
        for (int i = 0; i < exp_tx.size(); i++) begin
          total++; if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL rand_tx[%0d.%0d]: got %h want %h", f, i, obs_tx[i], exp_tx[i]); end
        end
      end
    end
    total++; if (excl_err !== 0) begin bad++; $display("FAIL we_re_exclusive: got %0d overlaps want 0", excl_err); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
    test_reset();
    test_read_basic();
    test_write_basic();
    test_wrap();
    test_cs_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
